// File: rtl/relu_stream_pkg.sv
// relu_stream_pkg: shared types and plane-major element helpers for the ReLU stream unit.
// Plane-major packing: bit b of element i lives at [b*elems + i].
package relu_stream_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLAMP  = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    // Helpers work on a fixed maximum-size container; callers zero-extend / truncate with casts.
    localparam int unsigned PLANE_MAX_DATA_W = 16;
    localparam int unsigned PLANE_MAX_ELEMS  = 256;
    localparam int unsigned PLANE_MAX_W      = PLANE_MAX_DATA_W * PLANE_MAX_ELEMS;
    localparam int unsigned PLANE_IDX_W      = $clog2(PLANE_MAX_W);
    localparam int unsigned PLANE_BIT_W      = $clog2(PLANE_MAX_DATA_W);

    typedef logic [PLANE_MAX_W-1:0]      plane_mat_t;
    typedef logic [PLANE_MAX_DATA_W-1:0] plane_elem_t;

    // Extract element idx from a plane-major matrix.
    function automatic plane_elem_t plane_get(input plane_mat_t m, input int unsigned data_w,
                                              input int unsigned elems, input int unsigned idx);
        plane_elem_t            r;
        logic [PLANE_IDX_W-1:0] pos;
        r = '0;
        for (int unsigned b = 0; b < PLANE_MAX_DATA_W; b++) begin
            if (b < data_w) begin
                pos = PLANE_IDX_W'(b * elems + idx);
                r[PLANE_BIT_W'(b)] = m[pos];
            end
        end
        return r;
    endfunction

    // Insert element idx into a plane-major matrix, returning the updated matrix.
    function automatic plane_mat_t plane_set(input plane_mat_t m, input plane_elem_t v,
                                             input int unsigned data_w, input int unsigned elems,
                                             input int unsigned idx);
        plane_mat_t             r;
        logic [PLANE_IDX_W-1:0] pos;
        r = m;
        for (int unsigned b = 0; b < PLANE_MAX_DATA_W; b++) begin
            if (b < data_w) begin
                pos = PLANE_IDX_W'(b * elems + idx);
                r[pos] = v[PLANE_BIT_W'(b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_stream_elem.sv
// relu_stream_elem: combinational single-element activation (ReLU / leaky / clamp / bypass).
module relu_stream_elem
    import relu_stream_pkg::*;
#(
    parameter int unsigned DATA_W     = 5,
    parameter int unsigned LEAK_SHIFT = 2,
    parameter int          CLAMP_MAX  = 7
) (
    input  logic [DATA_W-1:0] x,
    input  act_mode_e         mode,
    output logic [DATA_W-1:0] y,
    output logic              clipped
);

    localparam logic signed [DATA_W-1:0] CLAMP_V = DATA_W'(CLAMP_MAX);

    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] leak_v;

    // Apply the selected activation; flag any element whose value changed.
    always_comb begin
        xs     = x;
        leak_v = xs >>> LEAK_SHIFT;
        y      = x;
        case (mode)
            ACT_RELU: begin
                if (xs[DATA_W-1]) y = '0;
            end
            ACT_LEAKY: begin
                if (xs[DATA_W-1]) y = leak_v;
            end
            ACT_CLAMP: begin
                if (xs[DATA_W-1])      y = '0;
                else if (xs > CLAMP_V) y = CLAMP_V;
            end
            default: y = x;
        endcase
        clipped = (y != x);
    end

endmodule

// File: rtl/relu_stream_unit.sv
// relu_stream_unit: 2-stage valid/ready activation pipeline over a plane-major matrix beat.
// Optional build macro RELU_STREAM_STATS_EN adds stat_beats / stat_clips counters.
module relu_stream_unit
    import relu_stream_pkg::*;
#(
    parameter  int unsigned DATA_W     = 5,
    parameter  int unsigned ROW_LIMIT  = 10,
    parameter  int unsigned LEAK_SHIFT = 2,
    parameter  int          CLAMP_MAX  = 7,
    localparam int unsigned ELEMS      = ROW_LIMIT * ROW_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [DATA_W*ELEMS-1:0] in_matrix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*ELEMS-1:0] out_matrix,
`ifdef RELU_STREAM_STATS_EN
    output logic [31:0]             stat_beats,
    output logic [31:0]             stat_clips,
`endif
    output logic [ELEMS-1:0]        out_clipped
);

    localparam int unsigned MAT_W = DATA_W * ELEMS;

    logic              s1_valid_q,   s1_valid_d;
    logic [MAT_W-1:0]  s1_matrix_q,  s1_matrix_d;
    act_mode_e         s1_mode_q,    s1_mode_d;
    logic              s2_valid_q,   s2_valid_d;
    logic [MAT_W-1:0]  s2_matrix_q,  s2_matrix_d;
    logic [ELEMS-1:0]  s2_clipped_q, s2_clipped_d;

    logic              s2_adv;
    logic              s1_adv;
    logic [DATA_W-1:0] elem_x [ELEMS];
    logic [DATA_W-1:0] elem_y [ELEMS];
    logic [ELEMS-1:0]  elem_clip;
    plane_mat_t        res_mat;

    // Unpack the S1 matrix into per-element operands.
    always_comb begin
        for (int unsigned i = 0; i < ELEMS; i++) begin
            elem_x[i] = DATA_W'(plane_get(PLANE_MAX_W'(s1_matrix_q), DATA_W, ELEMS, i));
        end
    end

    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elem
        relu_stream_elem #(
            .DATA_W    (DATA_W),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLAMP_MAX (CLAMP_MAX)
        ) u_elem (
            .x      (elem_x[gi]),
            .mode   (s1_mode_q),
            .y      (elem_y[gi]),
            .clipped(elem_clip[gi])
        );
    end

    // Repack per-element results into plane-major order.
    always_comb begin
        res_mat = '0;
        for (int unsigned i = 0; i < ELEMS; i++) begin
            res_mat = plane_set(res_mat, PLANE_MAX_DATA_W'(elem_y[i]), DATA_W, ELEMS, i);
        end
    end

    // Pipeline advance: S2 moves when empty or handshaking, S1 when empty or moving into S2.
    always_comb begin
        s2_adv       = !s2_valid_q || out_ready;
        s1_adv       = !s1_valid_q || s2_adv;
        in_ready     = s1_adv;

        s1_valid_d   = s1_valid_q;
        s1_matrix_d  = s1_matrix_q;
        s1_mode_d    = s1_mode_q;
        s2_valid_d   = s2_valid_q;
        s2_matrix_d  = s2_matrix_q;
        s2_clipped_d = s2_clipped_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_matrix_d = in_matrix;
                s1_mode_d   = act_mode_e'(in_mode);
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_matrix_d  = MAT_W'(res_mat);
                s2_clipped_d = elem_clip;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_matrix_q  <= '0;
            s1_mode_q    <= ACT_RELU;
            s2_valid_q   <= 1'b0;
            s2_matrix_q  <= '0;
            s2_clipped_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_matrix_q  <= s1_matrix_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            s2_matrix_q  <= s2_matrix_d;
            s2_clipped_q <= s2_clipped_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_matrix  = s2_matrix_q;
    assign out_clipped = s2_clipped_q;

`ifdef RELU_STREAM_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_clips_q, stat_clips_d;
    logic [32:0] clips_sum;

    // Saturating beat and clip counters, updated on each output handshake.
    always_comb begin
        stat_beats_d = stat_beats_q;
        stat_clips_d = stat_clips_q;
        clips_sum    = {1'b0, stat_clips_q} + 33'($countones(s2_clipped_q));
        if (s2_valid_q && out_ready) begin
            if (stat_beats_q != '1) stat_beats_d = stat_beats_q + 32'd1;
            stat_clips_d = clips_sum[32] ? '1 : clips_sum[31:0];
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats_q <= '0;
            stat_clips_q <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_clips_q <= stat_clips_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_clips = stat_clips_q;
`endif

endmodule

// File: tb/tb_relu_stream_unit.sv
// tb_relu_stream_unit: directed self-checking bench for relu_stream_unit (default parameters).
// Optional build macro RELU_STREAM_STATS_EN enables the counter checks.
module tb_relu_stream_unit;

    localparam int unsigned DW = 5;
    localparam int unsigned EL = 100;
    localparam int unsigned MW = DW * EL;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [MW-1:0] in_matrix;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_matrix;
    logic [EL-1:0] out_clipped;
`ifdef RELU_STREAM_STATS_EN
    logic [31:0]   stat_beats;
    logic [31:0]   stat_clips;
`endif

    int checks = 0;
    int errors = 0;

    relu_stream_unit #(
        .DATA_W    (5),
        .ROW_LIMIT (10),
        .LEAK_SHIFT(2),
        .CLAMP_MAX (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_matrix  (in_matrix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_matrix (out_matrix),
`ifdef RELU_STREAM_STATS_EN
        .stat_beats (stat_beats),
        .stat_clips (stat_clips),
`endif
        .out_clipped(out_clipped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

    // Build a plane-major matrix with elements 0..3 set, all others zero.
    function automatic logic [MW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [MW-1:0] m;
        logic [DW-1:0] e;
        int            v [4];
        v = '{v0, v1, v2, v3};
        m = '0;
        for (int i = 0; i < 4; i++) begin
            e = DW'(v[i]);
            for (int b = 0; b < int'(DW); b++) m[b * int'(EL) + i] = e[b];
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat: checks acceptance, 2-cycle latency, result, clip flags and drain.
    task automatic run_beat(input string tag, input logic [1:0] mode, input logic [MW-1:0] xin,
                            input logic [MW-1:0] yexp, input logic [3:0] cexp);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_matrix = xin;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, MW'(in_ready), MW'(1));
        step();
        in_valid  = 1'b0;
        in_matrix = '0;
        check({tag, "_valid_c1"}, MW'(out_valid), MW'(0));
        step();
        check({tag, "_valid_c2"}, MW'(out_valid), MW'(1));
        check({tag, "_matrix"}, out_matrix, yexp);
        check({tag, "_clipped"}, MW'(out_clipped), MW'(cexp));
        step();
        check({tag, "_drained"}, MW'(out_valid), MW'(0));
    endtask

    initial begin
        int  sent;
        int  rcvd;
        int  seen;
        logic hs_in;
        logic hs_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_matrix = '0;
        out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", MW'(out_valid), MW'(0));
        check("rst_out_matrix", out_matrix, '0);
        check("rst_out_clipped", MW'(out_clipped), MW'(0));
        check("rst_in_ready", MW'(in_ready), MW'(1));

        // Activation modes
        run_beat("relu",   2'd0, pack4(-16, -1, 0, 15), pack4(0, 0, 0, 15),   4'b0011);
        run_beat("leaky",  2'd1, pack4(-8, -1, -16, 9), pack4(-2, -1, -4, 9), 4'b0101);
        run_beat("clamp",  2'd2, pack4(12, 7, -3, 0),   pack4(7, 7, 0, 0),    4'b0101);
        run_beat("bypass", 2'd3, pack4(-5, 15, -16, 1), pack4(-5, 15, -16, 1), 4'b0000);

        // Back-pressure: 8 beats, out_ready low for the first 5 cycles
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 8);
            in_mode   = 2'd3;
            in_matrix = pack4(sent + 1, 0, 0, 0);
            #1;
            if (c == 2) check("stall_in_ready_c2", MW'(in_ready), MW'(0));
            if (c == 4) begin
                check("stall_in_ready_c4", MW'(in_ready), MW'(0));
                check("stall_hold", out_matrix, pack4(1, 0, 0, 0));
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                check("stream_order", out_matrix, pack4(rcvd + 1, 0, 0, 0));
                rcvd++;
            end
            step();
            if (hs_in) sent++;
        end
        in_valid = 1'b0;
        check("stream_sent", MW'(sent), MW'(8));
        check("stream_rcvd", MW'(rcvd), MW'(8));
        step();
        check("stream_no_dup", MW'(out_valid), MW'(0));

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_matrix = pack4(5, 0, 0, 0);
        step();
        in_matrix = pack4(6, 0, 0, 0);
        step();
        in_valid = 1'b0;
        check("flight_out_valid", MW'(out_valid), MW'(1));
        check("flight_in_ready", MW'(in_ready), MW'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", MW'(out_valid), MW'(0));
        check("midrst_in_ready", MW'(in_ready), MW'(1));
        check("midrst_out_matrix", out_matrix, '0);
        check("midrst_out_clipped", MW'(out_clipped), MW'(0));
        out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            step();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", MW'(seen), MW'(0));

`ifdef RELU_STREAM_STATS_EN
        // Counters: 3 ReLU beats with 4 negatives each, then saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stat_rst_beats", MW'(stat_beats), MW'(0));
        out_ready = 1'b1;
        in_mode   = 2'd0;
        in_valid  = 1'b1;
        in_matrix = pack4(-1, -2, -3, -4);
        repeat (3) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("stat_beats", MW'(stat_beats), MW'(3));
        check("stat_clips", MW'(stat_clips), MW'(12));
        force dut.stat_beats_q = 32'hFFFF_FFFE;
        force dut.stat_clips_q = 32'hFFFF_FFFA;
        #1;
        release dut.stat_beats_q;
        release dut.stat_clips_q;
        in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("stat_beats_sat", MW'(stat_beats), MW'(32'hFFFF_FFFF));
        check("stat_clips_sat", MW'(stat_clips), MW'(32'hFFFF_FFFF));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
